// File: rtl/bsg_link_osdr_phy_multi.sv
// Multi-channel output PHY for bsg_link: registered channel data, a shared half-rate
// forwarded clock with wake/train/idle sequencing, and per-channel token edge detection.
module bsg_link_osdr_phy_multi #(
    parameter int unsigned width_p       = 8,
    parameter int unsigned channels_p    = 2,
    parameter int unsigned wake_cycles_p = 16,
    parameter logic [width_p-1:0] train_pattern_p = width_p'(8'hA5)
) (
    input  logic                             clk_i,
    input  logic                             reset_n_i,
    input  logic [1:0]                       mode_i,
    input  logic [channels_p*width_p-1:0]    data_i,
    output logic                             ready_o,
    output logic [channels_p-1:0]            clk_o,
    output logic [channels_p*width_p-1:0]    data_o,
    input  logic [channels_p-1:0]            token_i,
    output logic [channels_p-1:0]            token_edge_o,
    output logic [1:0]                       o_dbg_state
);

    // Handshake: data_i is consumed on every rising clk_i edge at which ready_o is high;
    // there is no backpressure from the core side, ready_o only reports acceptance.

    typedef enum logic [1:0] {
        S_WAKE   = 2'd0,
        S_ACTIVE = 2'd1,
        S_TRAIN  = 2'd2,
        S_IDLE   = 2'd3
    } state_e;

    localparam int unsigned CW = $clog2(wake_cycles_p + 1);
    localparam logic [CW-1:0] WAKE_MAX  = CW'(wake_cycles_p);
    localparam logic [CW-1:0] WAKE_LAST = CW'(wake_cycles_p - 1);
    localparam int unsigned DW = channels_p * width_p;

    state_e              r_state;
    state_e              w_state_next;
    state_e              w_req;
    logic                r_clk;
    logic                w_clk_next;
    logic [DW-1:0]       r_data;
    logic [DW-1:0]       w_data_next;
    logic [CW-1:0]       r_cnt;
    logic [CW-1:0]       w_cnt_next;

    logic [channels_p-1:0] r_sync1;
    logic [channels_p-1:0] r_sync2;
    logic [channels_p-1:0] r_sync_d;
    logic [channels_p-1:0] r_tok_edge;

    always_comb begin
        case (mode_i)
            2'd0:    w_req = S_ACTIVE;
            2'd1:    w_req = S_TRAIN;
            default: w_req = S_IDLE;
        endcase
    end

    always_comb begin
        w_state_next = r_state;
        w_clk_next   = r_clk;
        w_data_next  = r_data;
        w_cnt_next   = r_cnt;
        case (r_state)
            S_WAKE: begin
                w_clk_next  = ~r_clk;
                w_data_next = '0;
                if (r_cnt != WAKE_MAX) w_cnt_next = r_cnt + 1'b1;
                // Leave only on the toggle that brings the clock back low.
                if (r_cnt >= WAKE_LAST && r_clk) w_state_next = w_req;
            end
            S_ACTIVE: begin
                w_data_next  = data_i;
                w_clk_next   = (w_req == S_IDLE) ? 1'b0 : ~r_clk;
                w_state_next = w_req;
            end
            S_TRAIN: begin
                w_state_next = w_req;
                if (w_req == S_IDLE && !r_clk) begin
                    w_clk_next = 1'b0;
                end else begin
                    w_clk_next  = ~r_clk;
                    w_data_next = r_clk ? {channels_p{~train_pattern_p}}
                                        : {channels_p{train_pattern_p}};
                end
            end
            default: begin
                w_clk_next   = 1'b0;
                w_state_next = w_req;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state <= S_WAKE;
            r_clk   <= 1'b0;
            r_data  <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_clk   <= w_clk_next;
            r_data  <= w_data_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // The edge pulse is registered so it lands three cycles after the token rises.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_sync1    <= '0;
            r_sync2    <= '0;
            r_sync_d   <= '0;
            r_tok_edge <= '0;
        end else begin
            r_sync1    <= token_i;
            r_sync2    <= r_sync1;
            r_sync_d   <= r_sync2;
            r_tok_edge <= r_sync2 & ~r_sync_d;
        end
    end

    assign ready_o      = (r_state == S_ACTIVE);
    assign clk_o        = {channels_p{r_clk}};
    assign data_o       = r_data;
    assign token_edge_o = r_tok_edge;
    assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_bsg_link_osdr_phy_multi.sv
// Directed bench for bsg_link_osdr_phy_multi: wake sequence, mode table, idle gating,
// token edge detection and asynchronous reset restart.
module tb_bsg_link_osdr_phy_multi;

    logic        clk_i;
    logic        reset_n_i;
    logic [1:0]  mode_i;
    logic [15:0] data_i;
    logic        ready_o;
    logic [1:0]  clk_o;
    logic [15:0] data_o;
    logic [1:0]  token_i;
    logic [1:0]  token_edge_o;
    logic [1:0]  o_dbg_state;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [1:0]  mode;
        logic [15:0] data;
        logic        exp_clk;
        logic [15:0] exp_data;
        logic        exp_ready;
    } vec_t;

    vec_t vecs[21];

    bsg_link_osdr_phy_multi #(
        .width_p(8), .channels_p(2), .wake_cycles_p(16)
    ) dut (
        .clk_i        (clk_i),
        .reset_n_i    (reset_n_i),
        .mode_i       (mode_i),
        .data_i       (data_i),
        .ready_o      (ready_o),
        .clk_o        (clk_o),
        .data_o       (data_o),
        .token_i      (token_i),
        .token_edge_o (token_edge_o),
        .o_dbg_state  (o_dbg_state)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    // Runs the full wake sequence; mode_i is scrambled until the completing toggle.
    task automatic do_wake();
        for (int i = 1; i <= 16; i++) begin
            mode_i = (i == 16) ? 2'd0 : 2'($urandom_range(0, 3));
            data_i = 16'($urandom_range(1, 65535));
            step();
            chk($sformatf("wake_clk_%0d", i), 32'(clk_o), (i % 2 == 1) ? 32'h3 : 32'h0);
            chk($sformatf("wake_data_%0d", i), 32'(data_o), 32'h0);
            chk($sformatf("wake_ready_%0d", i), 32'(ready_o), (i == 16) ? 32'h1 : 32'h0);
        end
        chk("wake_state_active", 32'(o_dbg_state), 32'h1);
    endtask

    initial begin
        int pulses;
        vecs[0]  = '{2'd0, 16'h3412, 1'b1, 16'h3412, 1'b1};
        vecs[1]  = '{2'd0, 16'hBEEF, 1'b0, 16'hBEEF, 1'b1};
        vecs[2]  = '{2'd1, 16'h1111, 1'b1, 16'h1111, 1'b0};
        vecs[3]  = '{2'd1, 16'h2222, 1'b0, 16'h5A5A, 1'b0};
        vecs[4]  = '{2'd1, 16'h2222, 1'b1, 16'hA5A5, 1'b0};
        vecs[5]  = '{2'd1, 16'h2222, 1'b0, 16'h5A5A, 1'b0};
        vecs[6]  = '{2'd0, 16'h7777, 1'b1, 16'hA5A5, 1'b1};
        vecs[7]  = '{2'd2, 16'h0102, 1'b0, 16'h0102, 1'b0};
        vecs[8]  = '{2'd2, 16'h9999, 1'b0, 16'h0102, 1'b0};
        vecs[9]  = '{2'd0, 16'h8888, 1'b0, 16'h0102, 1'b1};
        vecs[10] = '{2'd0, 16'h4444, 1'b1, 16'h4444, 1'b1};
        vecs[11] = '{2'd3, 16'h5555, 1'b0, 16'h5555, 1'b0};
        vecs[12] = '{2'd1, 16'h6666, 1'b0, 16'h5555, 1'b0};
        vecs[13] = '{2'd1, 16'h6666, 1'b1, 16'hA5A5, 1'b0};
        vecs[14] = '{2'd1, 16'h6666, 1'b0, 16'h5A5A, 1'b0};
        vecs[15] = '{2'd2, 16'h6666, 1'b0, 16'h5A5A, 1'b0};
        vecs[16] = '{2'd2, 16'h6666, 1'b0, 16'h5A5A, 1'b0};
        vecs[17] = '{2'd0, 16'h0F0F, 1'b0, 16'h5A5A, 1'b1};
        vecs[18] = '{2'd2, 16'hF0F0, 1'b0, 16'hF0F0, 1'b0};
        vecs[19] = '{2'd0, 16'h1234, 1'b0, 16'hF0F0, 1'b1};
        vecs[20] = '{2'd0, 16'hABCD, 1'b1, 16'hABCD, 1'b1};

        reset_n_i = 1'b0;
        mode_i    = 2'd0;
        data_i    = 16'hFFFF;
        token_i   = 2'b00;
        repeat (3) @(negedge clk_i);
        chk("rst_clk", 32'(clk_o), 32'h0);
        chk("rst_data", 32'(data_o), 32'h0);
        chk("rst_ready", 32'(ready_o), 32'h0);
        chk("rst_tok", 32'(token_edge_o), 32'h0);
        chk("rst_state", 32'(o_dbg_state), 32'h0);
        reset_n_i = 1'b1;

        do_wake();

        for (int v = 0; v < 21; v++) begin
            mode_i = vecs[v].mode;
            data_i = vecs[v].data;
            step();
            chk($sformatf("vec%0d_clk", v), 32'(clk_o), 32'({2{vecs[v].exp_clk}}));
            chk($sformatf("vec%0d_data", v), 32'(data_o), 32'(vecs[v].exp_data));
            chk($sformatf("vec%0d_ready", v), 32'(ready_o), 32'(vecs[v].exp_ready));
        end

        // Token on channel 1 high for five cycles: one pulse, on the third edge.
        mode_i  = 2'd0;
        data_i  = 16'hCAFE;
        token_i = 2'b10;
        pulses  = 0;
        for (int i = 1; i <= 8; i++) begin
            step();
            if (i == 5) token_i = 2'b00;
            if (token_edge_o[1]) pulses++;
            chk($sformatf("tok_edge_%0d", i), 32'(token_edge_o), (i == 3) ? 32'h2 : 32'h0);
        end
        chk("tok_pulse_count", 32'(pulses), 32'h1);

        // Asynchronous reset between edges while ACTIVE with live data.
        data_i = 16'h5AA5;
        step();
        chk("pre_rst_data", 32'(data_o), 32'h5AA5);
        @(posedge clk_i);
        #2 reset_n_i = 1'b0;
        #1;
        chk("arst_clk", 32'(clk_o), 32'h0);
        chk("arst_data", 32'(data_o), 32'h0);
        chk("arst_ready", 32'(ready_o), 32'h0);
        chk("arst_state", 32'(o_dbg_state), 32'h0);
        @(negedge clk_i);
        reset_n_i = 1'b1;

        do_wake();
        mode_i = 2'd0;
        data_i = 16'h3412;
        step();
        chk("post_wake_clk", 32'(clk_o), 32'h3);
        chk("post_wake_data", 32'(data_o), 32'h3412);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
